// File: rtl/pwm_sample_scheduler.sv
// Paces signed audio samples into the PWM stage: one sample per PWM frame, with soft mute ramps.
// Latency: pwm_data updates only on the frame tick; a sample pushed into an empty FIFO in RUN shows at the next tick.
// Backpressure: in_ready = !full; muted and ramping-down states keep popping so the upstream never stalls.
module pwm_sample_scheduler #(
    parameter int DW         = 12,
    parameter int FRAME_LOG2 = 10,
    parameter int FIFO_LOG2  = 2,
    parameter int RAMP_STEP  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DW-1:0]       in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mute,
    output logic [DW-1:0]       pwm_data,
    output logic                frame_start,
    output logic [7:0]          underrun_cnt,
    output logic [1:0]          state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        RAMP  = 2'd2,
        MUTED = 2'd3
    } stateT;

    localparam int FRAME_MAX = 2**FRAME_LOG2 - 1;
    localparam logic [FIFO_LOG2:0] HALF_DEPTH = (FIFO_LOG2+1)'(2**(FIFO_LOG2-1));

    stateT                 stateQ, stateNext;
    logic [FRAME_LOG2-1:0] frameCnt;
    logic                  frameStartQ;
    logic                  tick;
    logic [DW-1:0]         pwmQ, pwmNext;
    logic [7:0]            urQ, urNext;
    logic                  popReq;
    logic [DW-1:0]         head;
    logic [FIFO_LOG2:0]    level;
    logic                  full, empty;

    // Ramp arithmetic: difference is one bit wider so it never wraps.
    logic [DW-1:0] target;
    logic [DW:0]   diff, absDiff;
    logic [DW-1:0] stepMag, stepped;
    logic          closeEnough;

    assign tick = (frameCnt == FRAME_LOG2'(FRAME_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frameCnt    <= '0;
            frameStartQ <= 1'b0;
        end else begin
            frameCnt    <= frameCnt + 1'b1;
            frameStartQ <= (frameCnt == FRAME_LOG2'(FRAME_MAX));
        end
    end

    smallFifo #(.W(DW), .LOG2(FIFO_LOG2)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .pushVld (in_valid),
        .pushDat (in_data),
        .popVld  (popReq),
        .headDat (head),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    assign target      = mute ? '0 : head;
    assign diff        = {target[DW-1], target} - {pwmQ[DW-1], pwmQ};
    assign absDiff     = diff[DW] ? (~diff + 1'b1) : diff;
    assign stepMag     = DW'(RAMP_STEP);
    assign closeEnough = (absDiff <= {1'b0, stepMag});
    // Only used when |diff| > step, so the result stays between pwm and target.
    assign stepped     = diff[DW] ? (pwmQ - stepMag) : (pwmQ + stepMag);

    always_comb begin
        stateNext = stateQ;
        pwmNext   = pwmQ;
        urNext    = urQ;
        popReq    = 1'b0;
        if (tick) begin
            case (stateQ)
                IDLE: begin
                    pwmNext = '0;
                    if (level >= HALF_DEPTH && !mute) begin
                        stateNext = RUN;
                        popReq    = 1'b1;
                        pwmNext   = head;
                    end
                end
                RUN: begin
                    if (mute) begin
                        stateNext = RAMP;
                    end else if (!empty) begin
                        popReq  = 1'b1;
                        pwmNext = head;
                    end else if (urQ != 8'hFF) begin
                        urNext = urQ + 1'b1;
                    end
                end
                RAMP: begin
                    if (mute || !empty) begin
                        popReq = mute;
                        if (closeEnough) begin
                            pwmNext = target;
                            if (mute) begin
                                stateNext = MUTED;
                            end else begin
                                stateNext = RUN;
                                popReq    = 1'b1;
                            end
                        end else begin
                            pwmNext = stepped;
                        end
                    end
                end
                MUTED: begin
                    pwmNext = '0;
                    if (mute) popReq = 1'b1;
                    else      stateNext = IDLE;
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
            pwmQ   <= '0;
            urQ    <= '0;
        end else begin
            stateQ <= stateNext;
            pwmQ   <= pwmNext;
            urQ    <= urNext;
        end
    end

    assign in_ready     = !full;
    assign pwm_data     = pwmQ;
    assign frame_start  = frameStartQ;
    assign underrun_cnt = urQ;
    assign state        = stateQ;
endmodule

// Generic first-word-fall-through FIFO; push and pop in the same cycle both take effect.
// Latency: head is valid the cycle after the first push.
// Backpressure: pushes while full and pops while empty are ignored.
module smallFifo #(
    parameter int W    = 12,
    parameter int LOG2 = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pushVld,
    input  logic [W-1:0]  pushDat,
    input  logic          popVld,
    output logic [W-1:0]  headDat,
    output logic [LOG2:0] level,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 2**LOG2;

    logic [W-1:0]    mem [DEPTH];
    logic [LOG2-1:0] wrPtr, rdPtr;
    logic [LOG2:0]   cnt;
    logic            doPush, doPop;

    assign full    = (cnt == (LOG2+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign doPush  = pushVld && !full;
    assign doPop   = popVld && !empty;
    assign headDat = mem[rdPtr];
    assign level   = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            cnt   <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr] <= pushDat;
                wrPtr      <= wrPtr + 1'b1;
            end
            if (doPop) rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule
